// File: rtl/taylor_pkg.sv
// Shared definitions for the Taylor-series datapath and its result collector.
// RES_W    : width of a datapath result.
// OV_CNT_W : width of the saturating overflow statistic.
// result_t : one result as it travels out of the datapath, {ov, y}.
package taylor_pkg;

  localparam int RES_W    = 32;
  localparam int OV_CNT_W = 8;

  typedef struct packed {
    logic             ov;
    logic [RES_W-1:0] y;
  } result_t;

endpackage

// File: rtl/result_fifo_mem.sv
// Storage array for result_fifo: DEPTH entries of result_t.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - entry to store
//   raddr - read address (asynchronous read)
//   rdata - entry at raddr
// The array has no reset; the top level tracks which entries are valid.
import taylor_pkg::*;

module result_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  result_t       wdata,
  input  logic [AW-1:0] raddr,
  output result_t       rdata
);

  result_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/result_fifo.sv
// Collects datapath results ({ov_ans, Y}) into a show-ahead FIFO and hands
// them to a consumer over a valid/ready handshake.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   valid_ans, Y,     - incoming result strobe, data and overflow flag
//   ov_ans
//   clr               - clears the dropped flag and ov_count
//   out_valid,        - head entry handshake towards the consumer
//   out_ready
//   out_y, out_ov     - head entry, forced to 0 while empty
//   count, full,      - occupancy and flags derived from it
//   empty, hold
//   dropped           - sticky: a result arrived while full with no read
//   ov_count          - saturating count of accepted entries with ov set
import taylor_pkg::*;

module result_fifo #(
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_ans,
  input  logic [RES_W-1:0]           Y,
  input  logic                       ov_ans,
  input  logic                       clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RES_W-1:0]           out_y,
  output logic                       out_ov,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       hold,
  output logic                       dropped,
  output logic [OV_CNT_W-1:0]        ov_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]       AFULL_C = CW'(AFULL_LEVEL);
  localparam logic [OV_CNT_W-1:0] OV_MAX  = '1;

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                dropped_q, dropped_d;
  logic [OV_CNT_W-1:0] ov_count_q, ov_count_d;
  logic [OV_CNT_W-1:0] ov_base;

  logic    wr;
  logic    rd;
  result_t wdata;
  result_t rdata;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign hold      = (count_q >= AFULL_C);
  assign out_valid = !empty;
  assign count     = count_q;
  assign dropped   = dropped_q;
  assign ov_count  = ov_count_q;

  assign out_y  = empty ? '0 : rdata.y;
  assign out_ov = empty ? 1'b0 : rdata.ov;

  // A full FIFO can still accept a write when the head leaves in the same
  // cycle, which keeps back-to-back streaming at one entry per clock.
  assign rd    = out_valid & out_ready;
  assign wr    = valid_ans & (!full | rd);
  assign wdata = '{ov: ov_ans, y: Y};

  result_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dropped_d  = dropped_q;
    ov_count_d = ov_count_q;

    if (wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (wr && !rd) begin
      count_d = count_q + CW'(1);
    end else if (rd && !wr) begin
      count_d = count_q - CW'(1);
    end

    // clr is applied first so a same-cycle event overrides it.
    if (clr) begin
      dropped_d = 1'b0;
    end
    if (valid_ans && !wr) begin
      dropped_d = 1'b1;
    end

    ov_base    = clr ? '0 : ov_count_q;
    ov_count_d = ov_base;
    if (wr && ov_ans && (ov_base != OV_MAX)) begin
      ov_count_d = ov_base + OV_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dropped_q  <= 1'b0;
      ov_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dropped_q  <= dropped_d;
      ov_count_q <= ov_count_d;
    end
  end

endmodule

// File: doc/result_fifo.md
# result_fifo

Downstream collector for the Taylor-series datapath. Each cycle the datapath asserts `valid_ans`, this block captures the 32-bit result `Y` and its overflow flag `ov_ans` into a small FIFO. It presents them to the consumer over a valid/ready handshake and raises `hold` so the controller can deassert `en_all` before the buffer overflows. It also keeps sticky drop and saturating overflow statistics.

## Interface

Parameters:
- `DEPTH`, 8: number of entries; must be a power of two and ≥ 2.
- `AFULL_LEVEL`, 6: occupancy at or above which `hold` asserts; range 1..DEPTH.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `valid_ans`  in  1  datapath result strobe; each high cycle is one result.
- `Y`  in  32  datapath result; sampled only when `valid_ans`=1.
- `ov_ans`  in  1  overflow flag for that result.
- `clr`  in  1  clears `dropped` and `ov_count`; pointers are untouched.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_y`  out  32  head result; 0 when empty.
- `out_ov`  out  1  head overflow flag; 0 when empty.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `full`  out  1  `count`==DEPTH.
- `empty`  out  1  `count`==0.
- `hold`  out  1  `count`≥AFULL_LEVEL; goes to the controller.
- `dropped`  out  1  sticky: a result was lost.
- `ov_count`  out  8  saturating count of accepted entries with ov=1.

## Operation

- Entry format: {ov, Y[31:0]}, 33 bits.
- `wr` = `valid_ans` & (!`full` | `rd`).
- `rd` = `out_valid` & `out_ready`.
- On `wr`: the entry is written to `mem[wr_ptr]` and `wr_ptr` increments modulo DEPTH.
- On `rd`: `rd_ptr` increments modulo DEPTH.
- `count` next value: +1 on `wr` only, −1 on `rd` only, unchanged when both or neither occur.
- The FIFO is show-ahead. `out_y` and `out_ov` are `mem[rd_ptr]` gated to 0 when empty. `out_valid` = !`empty`.
- Full with simultaneous `rd`: the write is accepted and `count` stays at DEPTH.
- Full without `rd`, with `valid_ans`=1: the result is discarded, `dropped` is set, and memory and pointers are unchanged.
- Empty with `valid_ans`: there is no bypass. The data appears at the output the next cycle.
- `out_ready` while empty is ignored; no underflow.
- `ov_count` increments on `wr` & `ov_ans`, and saturates at 255.
- `clr` zeroes `dropped` and `ov_count`. If a set/increment event occurs in the same cycle, the event wins: `dropped`=1 or `ov_count`=1.
- `out_*` are stable while `out_valid`=1 and `out_ready`=0.

## Timing

- Reset values, one cycle after `rst`=1:
  - `wr_ptr`, `rd_ptr`, `count`, `ov_count` = 0.
  - `empty`=1, `full`=0, `hold`=0, `dropped`=0, `out_valid`=0.
  - `out_y`=0, `out_ov`=0.
  - Memory contents are not reset.
- `rst` mid-stream discards all entries. It takes priority over `valid_ans`, `out_ready` and `clr` in the same cycle.
- Write-to-output latency: 1 cycle. `valid_ans` at edge N makes the entry visible after edge N.
- `full`, `empty` and `hold` are derived combinationally from registered `count`; they carry no extra latency.
- `hold` asserts the cycle after the accepting write that brings `count` to AFULL_LEVEL. The controller's one-cycle reaction then leaves DEPTH−AFULL_LEVEL slots of margin.
- Throughput: one write and one read per cycle, sustained.

## Structure

- Shared package `taylor_pkg`:
  - `RES_W` = 32.
  - Typedef `result_t` = {ov, y}.
  - Also used by the datapath output mux.
- Sub-module `result_fifo_mem`:
  - DEPTH×33 register array.
  - One write port (`we`, `waddr`, `wdata`) and one asynchronous read port (`raddr`, `rdata`).
  - No reset.
- The top level holds the pointers, `count`, flags and statistics.

## Test plan

- Reset, then write three results with `out_ready`=0: Y=0x00010000/ov0, 0x00020000/ov1, 0x7FFF0000/ov0. Required: `count`=3, `out_y`=0x00010000, `ov_count`=1, `hold`=0.
- Fill to 8 with `out_ready`=0. Required:
  - `hold`=1 once `count`=6; `full`=1 at 8.
  - A 9th `valid_ans` (Y=0xDEAD0000) leaves `count`=8 and sets `dropped`=1.
  - Draining afterwards never presents 0xDEAD0000.
- Full FIFO with `valid_ans` and `out_ready` both high for 4 cycles. Required: `count` stays 8, no drop, FIFO order preserved across pointer wrap.
- Empty FIFO, single write, `out_ready` held at 1. Required: `out_valid` high for exactly one cycle, data matches, then `empty`=1 and `out_y`=0.
- 300 writes with ov=1 and continuous read. Required: `ov_count`=255. Then `clr` in the same cycle as an ov=1 write gives `ov_count`=1.
- Assert `rst` with 5 entries queued and `valid_ans`=1. Required: next cycle `count`=0, `empty`=1, `dropped`=0, `out_y`=0.
